// File: rtl/bar_pkg.sv
// Shared defaults, bar array type and FSM state encoding for the bar_writer slice.
package bar_pkg;

   localparam int NUM_BARS     = 16;
   localparam int BINS_PER_BAR = 16;
   localparam int DECAY_SHIFT  = 3;
   localparam int BIN_W        = 16;

   typedef logic [NUM_BARS-1:0][BIN_W-1:0] bar_array_t;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      FULL   = 2'd1,
      UPDATE = 2'd2
   } bar_state_t;

endpackage

// File: rtl/bar_writer_if.sv
// Valid/ready magnitude-bin stream feeding bar_writer.
interface bar_writer_if;
   import bar_pkg::*;

   logic             bin_valid;
   logic             bin_ready;
   logic [BIN_W-1:0] bin_mag;
   logic             bin_last;

   modport master (output bin_valid, output bin_mag, output bin_last, input bin_ready);
   modport slave  (input bin_valid, input bin_mag, input bin_last, output bin_ready);

endinterface

// File: rtl/bar_decay.sv
// One-bar peak-hold step: next = max(pending, decay(current)), never underflows.
module bar_decay
   import bar_pkg::*;
#(
   parameter int DECAY_SHIFT = bar_pkg::DECAY_SHIFT
)(
   input  logic [BIN_W-1:0] pending,
   input  logic [BIN_W-1:0] current,
   output logic [BIN_W-1:0] next
);

   logic [BIN_W-1:0] step;
   logic [BIN_W-1:0] decayed;

   always_comb begin
      step = current >> DECAY_SHIFT;
      // Small values still fall by one per frame so bars always reach zero.
      if (step != '0)
         decayed = current - step;
      else if (current != '0)
         decayed = current - 1'b1;
      else
         decayed = '0;
      next = (pending > decayed) ? pending : decayed;
   end

endmodule

// File: rtl/bar_writer.sv
// Folds a frame of spectral bins into per-bar peaks and publishes them with
// peak-hold decay, one bar per cycle, during vertical blanking.
module bar_writer
   import bar_pkg::*;
#(
   parameter int NUM_BARS     = bar_pkg::NUM_BARS,
   parameter int BINS_PER_BAR = bar_pkg::BINS_PER_BAR,
   parameter int DECAY_SHIFT  = bar_pkg::DECAY_SHIFT
)(
   input  logic                            fsm_clk,
   input  logic                            reset_n,
   bar_writer_if.slave                     bin,
   input  logic                            frame_sync,
   output logic [NUM_BARS-1:0][BIN_W-1:0]  bars,
   output logic                            frame_done,
   output logic                            frame_dropped,
   output logic                            bin_overflow
);

   localparam int IW = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
   localparam int CW = (BINS_PER_BAR > 1) ? $clog2(BINS_PER_BAR) : 1;
   localparam int BW = $clog2(NUM_BARS + 1);

   bar_state_t                     state;
   logic [NUM_BARS-1:0][BIN_W-1:0] pending;
   logic [BIN_W-1:0]               work;
   logic [BIN_W-1:0]               new_work;
   logic [BIN_W-1:0]               decay_next;
   logic [CW-1:0]                  bin_cnt;
   logic [BW-1:0]                  bar_idx;
   logic [IW-1:0]                  bar_sel;
   logic [IW-1:0]                  upd_idx;
   logic                           xfer;
   logic                           frame_full;

   assign bin.bin_ready = (state == ACCUM);
   assign xfer          = bin.bin_valid && bin.bin_ready;
   // bar_idx reaching NUM_BARS means every bar of this frame is already committed.
   assign frame_full    = (bar_idx == BW'(NUM_BARS));
   assign bar_sel       = bar_idx[IW-1:0];
   assign new_work      = (bin.bin_mag > work) ? bin.bin_mag : work;

   bar_decay #(.DECAY_SHIFT(DECAY_SHIFT)) u_decay (
      .pending (pending[upd_idx]),
      .current (bars[upd_idx]),
      .next    (decay_next)
   );

   always_ff @(posedge fsm_clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ACCUM;
         pending       <= '0;
         work          <= '0;
         bin_cnt       <= '0;
         bar_idx       <= '0;
         upd_idx       <= '0;
         frame_done    <= 1'b0;
         frame_dropped <= 1'b0;
         bin_overflow  <= 1'b0;
      end else begin
         frame_done    <= 1'b0;
         frame_dropped <= 1'b0;
         case (state)
            ACCUM: begin
               if (frame_sync && !(xfer && bin.bin_last))
                  frame_dropped <= 1'b1;
               if (xfer) begin
                  if (frame_full)
                     bin_overflow <= 1'b1;
                  if (bin.bin_last) begin
                     if (!frame_full) begin
                        for (int unsigned j = 0; j < NUM_BARS; j++)
                           if (j > 32'(bar_idx))
                              pending[j] <= '0;
                        pending[bar_sel] <= new_work;
                     end
                     work    <= '0;
                     bin_cnt <= '0;
                     bar_idx <= '0;
                     state   <= FULL;
                  end else if (!frame_full) begin
                     if (bin_cnt == CW'(BINS_PER_BAR - 1)) begin
                        pending[bar_sel] <= new_work;
                        work             <= '0;
                        bin_cnt          <= '0;
                        bar_idx          <= bar_idx + 1'b1;
                     end else begin
                        work    <= new_work;
                        bin_cnt <= bin_cnt + 1'b1;
                     end
                  end
               end
            end
            FULL: begin
               if (frame_sync) begin
                  state   <= UPDATE;
                  upd_idx <= '0;
               end
            end
            UPDATE: begin
               if (upd_idx == IW'(NUM_BARS - 1)) begin
                  state      <= ACCUM;
                  frame_done <= 1'b1;
               end else begin
                  upd_idx <= upd_idx + 1'b1;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

   always_ff @(posedge fsm_clk or negedge reset_n) begin
      if (!reset_n)
         bars <= '0;
      else if (state == UPDATE)
         bars[upd_idx] <= decay_next;
   end

endmodule

// File: tb/tb_bar_writer.sv
// Directed self-checking bench for bar_writer with hand-computed expectations.
module tb_bar_writer;
   import bar_pkg::*;

   logic       fsm_clk    = 1'b0;
   logic       reset_n    = 1'b0;
   logic       frame_sync = 1'b0;
   bar_array_t bars;
   logic       frame_done;
   logic       frame_dropped;
   logic       bin_overflow;
   int         total = 0;
   int         bad   = 0;
   int         lat;
   int         dec_exp[3]   = '{700, 613, 537};
   int         small_exp[6] = '{4, 3, 2, 1, 0, 0};

   bar_writer_if bin_if ();

   bar_writer #(
      .NUM_BARS     (16),
      .BINS_PER_BAR (16),
      .DECAY_SHIFT  (3)
   ) dut (
      .fsm_clk       (fsm_clk),
      .reset_n       (reset_n),
      .bin           (bin_if),
      .frame_sync    (frame_sync),
      .bars          (bars),
      .frame_done    (frame_done),
      .frame_dropped (frame_dropped),
      .bin_overflow  (bin_overflow)
   );

   always #5 fsm_clk = ~fsm_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called at a negedge; one bin per cycle, returns at the next negedge.
   task automatic send_bin(input logic [15:0] m, input logic l);
      bin_if.bin_valid = 1'b1;
      bin_if.bin_mag   = m;
      bin_if.bin_last  = l;
      @(posedge fsm_clk);
      @(negedge fsm_clk);
      bin_if.bin_valid = 1'b0;
      bin_if.bin_last  = 1'b0;
   endtask

   task automatic send_ramp();
      for (int k = 0; k < 256; k++)
         send_bin(16'(k * 16), k == 255);
   endtask

   task automatic publish();
      bin_if.bin_valid = 1'b0;
      frame_sync = 1'b1;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge fsm_clk);
         frame_sync = 1'b0;
         if (frame_done) begin
            lat = n;
            break;
         end
      end
      check("done_lat", lat, 17);
      check("ready_after_pub", bin_if.bin_ready, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bin_if.bin_valid = 1'b0;
      bin_if.bin_mag   = '0;
      bin_if.bin_last  = 1'b0;
      repeat (2) @(negedge fsm_clk);
      check("rst_bar0", bars[0], 0);
      check("rst_bar15", bars[15], 0);
      check("rst_done", frame_done, 0);
      check("rst_drop", frame_dropped, 0);
      check("rst_ovf", bin_overflow, 0);
      reset_n = 1'b1;
      @(negedge fsm_clk);
      check("rst_ready", bin_if.bin_ready, 1);

      // Ramp frame: bar i peak is bin 16i+15.
      send_ramp();
      check("full_ready", bin_if.bin_ready, 0);
      publish();
      for (int i = 0; i < 16; i++)
         check("ramp_bar", bars[i], (16 * i + 15) * 16);
      @(negedge fsm_clk);
      check("done_pulse", frame_done, 0);

      // Peak hold: 800 then decaying frames; bar1 decays 496 -> 434.
      send_bin(16'd800, 1'b1);
      publish();
      check("dec_800", bars[0], 800);
      check("dec_bar1", bars[1], 434);
      for (int i = 0; i < 3; i++) begin
         send_bin(16'd0, 1'b1);
         publish();
         check("dec_seq", bars[0], dec_exp[i]);
      end

      // Small values fall by one per frame down to zero.
      reset_n = 1'b0;
      @(negedge fsm_clk);
      reset_n = 1'b1;
      send_bin(16'd5, 1'b1);
      publish();
      check("small_5", bars[0], 5);
      for (int i = 0; i < 6; i++) begin
         send_bin(16'd0, 1'b1);
         publish();
         check("small_seq", bars[0], small_exp[i]);
      end

      // Short frame: bin_last on bin 20.
      for (int k = 0; k <= 20; k++)
         send_bin(16'd100, k == 20);
      publish();
      check("short_bar0", bars[0], 100);
      check("short_bar1", bars[1], 100);
      check("short_bar2", bars[2], 0);
      check("short_bar15", bars[15], 0);

      // frame_sync during accumulation is dropped; accumulation continues.
      for (int k = 0; k < 8; k++)
         send_bin(16'd300, 1'b0);
      frame_sync = 1'b1;
      check("drop_ready", bin_if.bin_ready, 1);
      @(negedge fsm_clk);
      frame_sync = 1'b0;
      check("drop_pulse", frame_dropped, 1);
      check("drop_bars", bars[0], 100);
      @(negedge fsm_clk);
      check("drop_clr", frame_dropped, 0);
      for (int k = 0; k < 8; k++)
         send_bin(16'd50, 1'b0);
      send_bin(16'd200, 1'b1);
      publish();
      check("drop_bar0", bars[0], 300);
      check("drop_bar1", bars[1], 200);
      check("drop_bar2", bars[2], 0);

      // Overflow: bins 256..299 must be discarded.
      reset_n = 1'b0;
      @(negedge fsm_clk);
      reset_n = 1'b1;
      for (int k = 0; k < 300; k++)
         send_bin((k < 256) ? 16'd20 : 16'd9000, k == 299);
      check("ovf_flag", bin_overflow, 1);
      bin_if.bin_valid = 1'b1;
      bin_if.bin_mag   = 16'd9999;
      repeat (3) begin
         @(negedge fsm_clk);
         check("full_hold", bin_if.bin_ready, 0);
      end
      publish();
      check("ovf_bar0", bars[0], 20);
      check("ovf_bar15", bars[15], 20);
      check("ovf_sticky", bin_overflow, 1);

      // Reset in the middle of a publish.
      send_ramp();
      frame_sync = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(negedge fsm_clk);
         frame_sync = 1'b0;
      end
      check("mid_bar0", bars[0], 240);
      reset_n = 1'b0;
      #1;
      check("mid_rst_bar0", bars[0], 0);
      check("mid_rst_bar3", bars[3], 0);
      check("mid_rst_bar15", bars[15], 0);
      check("mid_rst_ovf", bin_overflow, 0);
      @(negedge fsm_clk);
      reset_n = 1'b1;
      check("mid_rst_ready", bin_if.bin_ready, 1);
      send_ramp();
      publish();
      check("post_bar0", bars[0], 240);
      check("post_bar7", bars[7], 2032);
      check("post_bar15", bars[15], 4080);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
